// File: rtl/tmds_ser_pkg.sv
// tmds_ser_pkg: shared TMDS serializer constants and the clock-lane pattern helper.
// Contents: default lane count and word width, the four TMDS control tokens,
// and clk_pattern(), which builds the word-aligned clock-lane word.
package tmds_ser_pkg;
    localparam int TMDS_WORD_W = 10;
    localparam int TMDS_NUM_CH = 3;
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    // The first ceil(width/2) transmitted bits are 1, the rest 0.
    function automatic logic [15:0] clk_pattern(input int width, input bit msb_first);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++)
            if (i < width)
                p[i] = msb_first ? (i >= width / 2) : (i < (width + 1) / 2);
        return p;
    endfunction
endpackage

// File: rtl/tmds_ser_lane.sv
// tmds_ser_lane: one shift register with load, clear and selectable bit order.
// Ports: clk/rst_n clock and async active-low reset; clr zeroes the register;
// load captures din (takes priority); dout is the bit currently on the wire.
module tmds_ser_lane #(
    parameter int W = 10,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic         dout
);
    logic [W-1:0] sh;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            sh <= '0;
        else if (load)
            sh <= din;
        else if (clr)
            sh <= '0;
        else
            sh <= MSB_FIRST ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};

    assign dout = MSB_FIRST ? sh[W-1] : sh[0];
endmodule

// File: rtl/tmds_serializer_gen.sv
// tmds_serializer_gen: parametrised TMDS word-to-bit serializer in the serial clock domain.
// Ports: clk_TMDS/rst_n bit clock and async active-low reset; en enables shifting;
// word_in/word_valid/word_ready valid-ready word supply into a one-entry hold;
// ser_out per-lane serial bits; clk_out clock-lane bit; word_load load pulse;
// underrun/underrun_cnt sticky flag and saturating count, cleared by underrun_clr.
module tmds_serializer_gen
    import tmds_ser_pkg::*;
#(
    parameter int NUM_CH = TMDS_NUM_CH,
    parameter int WORD_W = TMDS_WORD_W,
    parameter bit MSB_FIRST = 1'b0,
    parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(TMDS_CTRL_00),
    parameter int CNT_W = 16
) (
    input  logic                     clk_TMDS,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_CH*WORD_W-1:0] word_in,
    input  logic                     word_valid,
    output logic                     word_ready,
    output logic [NUM_CH-1:0]        ser_out,
    output logic                     clk_out,
    output logic                     word_load,
    output logic                     underrun,
    output logic [CNT_W-1:0]         underrun_cnt,
    input  logic                     underrun_clr
);
    localparam int BW = $clog2(WORD_W);
    localparam logic [WORD_W-1:0] CLK_PAT = WORD_W'(clk_pattern(WORD_W, MSB_FIRST));

    logic [BW-1:0]            bit_cnt;
    logic [NUM_CH*WORD_W-1:0] hold;
    logic                     hold_full;
    logic                     load_now;
    logic                     accept;
    logic                     ev;

    assign load_now   = en && bit_cnt == BW'(WORD_W - 1);
    assign word_load  = load_now;
    assign word_ready = !hold_full || load_now;
    assign accept     = word_valid && word_ready;
    assign ev         = load_now && !hold_full;

    always_ff @(posedge clk_TMDS or negedge rst_n)
        if (!rst_n)
            bit_cnt <= '0;
        else
            bit_cnt <= (en && !load_now) ? bit_cnt + 1'b1 : '0;

    // On a simultaneous accept and load the old hold word is already on its
    // way into the lanes, so the new word simply replaces it.
    always_ff @(posedge clk_TMDS or negedge rst_n)
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (accept)
                hold <= word_in;
            hold_full <= accept || (hold_full && !load_now);
        end

    // An event beats a clear: the cleared counter restarts at one.
    always_ff @(posedge clk_TMDS or negedge rst_n)
        if (!rst_n) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (ev) begin
            underrun     <= 1'b1;
            underrun_cnt <= underrun_clr ? CNT_W'(1) :
                            (&underrun_cnt ? underrun_cnt : underrun_cnt + 1'b1);
        end else if (underrun_clr) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        tmds_ser_lane #(.W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_lane (
            .clk  (clk_TMDS),
            .rst_n(rst_n),
            .clr  (!en),
            .load (load_now),
            .din  (hold_full ? hold[c*WORD_W +: WORD_W] : IDLE_WORD),
            .dout (ser_out[c])
        );
    end

    tmds_ser_lane #(.W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_clk_lane (
        .clk  (clk_TMDS),
        .rst_n(rst_n),
        .clr  (!en),
        .load (load_now),
        .din  (CLK_PAT),
        .dout (clk_out)
    );
endmodule
